// File: rtl/mmio_io_ctrl_if.sv
// mmio_io_ctrl_if: CPU-side register bus for the memory-mapped I/O controller.
//  sel    CPU access targets the I/O space
//  we     write strobe, qualified by sel
//  addr   byte offset within the I/O space
//  wdata  CPU write data
//  rdata  combinational read data from the controller
interface mmio_io_ctrl_if;
    logic        sel;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output sel, we, addr, wdata, input rdata);
    modport slave (input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: LED/HEX output registers, synced switches, debounced keys with sticky W1C edges and irq.
//  clk         system clock
//  reset       synchronous, active-low
//  bus         CPU register bus (slave side), offset decoded from addr[7:2]
//  key_n       raw push-buttons, 0 = pressed
//  sw          raw slide switches
//  ledr        LED register
//  hex_digits  nibble per digit, digit 0 in [3:0]
//  irq         registered |(key_edge & key_irq_en)
module mmio_io_ctrl #(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 10,
    parameter int N_LEDS          = 10,
    parameter int N_HEX           = 6,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_io_ctrl_if.slave        bus,
    input  logic [N_KEYS-1:0]    key_n,
    input  logic [N_SW-1:0]      sw,
    output logic [N_LEDS-1:0]    ledr,
    output logic [4*N_HEX-1:0]   hex_digits,
    output logic                 irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0] OFF_LEDS = 6'd0, OFF_HEX = 6'd1, OFF_KEY = 6'd2,
                           OFF_SW = 6'd3, OFF_EDGE = 6'd4, OFF_EN = 6'd5;

    logic [5:0]        off;
    logic              wr;
    logic [N_KEYS-1:0] key_s1, key_s2, pressed, stable, accept, rise, edge_clr;
    logic [N_KEYS-1:0] key_edge, key_irq_en;
    logic [N_SW-1:0]   sw_s1, sw_s2;
    logic [CW-1:0]     cnt [N_KEYS];
    logic              unused;

    assign off      = bus.addr[7:2];
    assign wr       = bus.sel & bus.we;
    assign pressed  = ~key_s2;
    assign unused   = ^{bus.addr[1:0], bus.wdata};

    // A key flips its stable value on the last of DEBOUNCE_CYCLES consecutive mismatches.
    for (genvar k = 0; k < N_KEYS; k++) begin : g_deb
        assign accept[k] = (pressed[k] != stable[k]) && (cnt[k] == CNT_MAX);
    end

    // accept implies pressed differs from stable, so pressed=1 marks a press.
    assign rise     = accept & pressed;
    assign edge_clr = (wr && off == OFF_EDGE) ? bus.wdata[N_KEYS-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            key_s1     <= '1;
            key_s2     <= '1;
            sw_s1      <= '0;
            sw_s2      <= '0;
            stable     <= '0;
            key_edge   <= '0;
            key_irq_en <= '0;
            irq        <= 1'b0;
            ledr       <= '0;
            hex_digits <= '0;
            for (int i = 0; i < N_KEYS; i++) cnt[i] <= '0;
        end else begin
            key_s1   <= key_n;
            key_s2   <= key_s1;
            sw_s1    <= sw;
            sw_s2    <= sw_s1;
            stable   <= stable ^ accept;
            // A press landing with a clear on the same bit keeps the bit set.
            key_edge <= (key_edge & ~edge_clr) | rise;
            irq      <= |(key_edge & key_irq_en);
            if (wr && off == OFF_LEDS) ledr <= bus.wdata[N_LEDS-1:0];
            if (wr && off == OFF_HEX) hex_digits <= bus.wdata[4*N_HEX-1:0];
            if (wr && off == OFF_EN) key_irq_en <= bus.wdata[N_KEYS-1:0];
            for (int i = 0; i < N_KEYS; i++)
                cnt[i] <= (pressed[i] == stable[i] || accept[i]) ? '0 : cnt[i] + CW'(1);
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.sel) begin
            case (off)
                OFF_LEDS: bus.rdata = 32'(ledr);
                OFF_HEX:  bus.rdata = 32'(hex_digits);
                OFF_KEY:  bus.rdata = 32'(stable);
                OFF_SW:   bus.rdata = 32'(sw_s2);
                OFF_EDGE: bus.rdata = 32'(key_edge);
                OFF_EN:   bus.rdata = 32'(key_irq_en);
                default:  bus.rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl: directed scoreboard bench for mmio_io_ctrl with default parameters.
module tb_mmio_io_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  key_n = '1;
    logic [9:0]  sw = '0;
    logic [9:0]  ledr;
    logic [23:0] hex_digits;
    logic        irq;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    mmio_io_ctrl_if bus();

    mmio_io_ctrl dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .key_n(key_n),
        .sw(sw),
        .ledr(ledr),
        .hex_digits(hex_digits),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL sb_empty: got %h want <none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s: got %h want %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.sel = 1'b1;
        bus.we = 1'b1;
        bus.addr = a;
        bus.wdata = d;
        tick();
        bus.sel = 1'b0;
        bus.we = 1'b0;
    endtask

    task automatic rdc(input logic [7:0] a, input string tag, input logic [31:0] v);
        push_exp(tag, v);
        bus.sel = 1'b1;
        bus.we = 1'b0;
        bus.addr = a;
        #1;
        check(bus.rdata);
        bus.sel = 1'b0;
    endtask

    initial begin
        bus.sel = 1'b0;
        bus.we = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        key_n = 4'b0000;
        sw = 10'h3FF;
        tick(3);
        push_exp("rst_ledr", 32'h0);
        check(32'(ledr));
        push_exp("rst_hex", 32'h0);
        check(32'(hex_digits));
        push_exp("rst_irq", 32'h0);
        check(32'(irq));
        rdc(8'h08, "rst_key", 32'h0);
        rdc(8'h10, "rst_edge", 32'h0);
        key_n = 4'b1111;
        reset = 1'b1;
        tick(3);

        push_exp("ledr_wr", 32'h2A5);
        wr(8'h00, 32'hFFFF_F2A5);
        check(32'(ledr));
        rdc(8'h00, "ledr_rd", 32'h2A5);
        push_exp("hex_wr", 32'h00AB_CDEF);
        wr(8'h04, 32'h00AB_CDEF);
        check(32'(hex_digits));
        rdc(8'h04, "hex_rd", 32'h00AB_CDEF);
        rdc(8'h0C, "sw_init", 32'h3FF);
        bus.addr = 8'h00;
        #1;
        push_exp("nosel_rd", 32'h0);
        check(bus.rdata);

        key_n[1] = 1'b0;
        tick(10);
        key_n[1] = 1'b1;
        tick(30);
        rdc(8'h08, "glitch_key", 32'h0);
        rdc(8'h10, "glitch_edge", 32'h0);

        wr(8'h14, 32'h2);
        rdc(8'h14, "en_rd", 32'h2);
        key_n[1] = 1'b0;
        tick(17);
        rdc(8'h08, "key_pre", 32'h0);
        tick(1);
        rdc(8'h08, "key_18", 32'h2);
        rdc(8'h10, "edge_set", 32'h2);
        push_exp("irq_lag", 32'h0);
        check(32'(irq));
        tick(1);
        push_exp("irq_set", 32'h1);
        check(32'(irq));
        wr(8'h10, 32'h2);
        push_exp("irq_hold", 32'h1);
        check(32'(irq));
        rdc(8'h10, "edge_clr", 32'h0);
        tick(1);
        push_exp("irq_clr", 32'h0);
        check(32'(irq));

        key_n[1] = 1'b1;
        tick(18);
        rdc(8'h08, "key_rel", 32'h0);
        rdc(8'h10, "edge_rel", 32'h0);

        key_n[0] = 1'b0;
        tick(17);
        wr(8'h10, 32'h1);
        rdc(8'h10, "collide", 32'h1);
        rdc(8'h08, "key0", 32'h1);
        push_exp("irq_masked", 32'h0);
        check(32'(irq));
        wr(8'h10, 32'h1);
        rdc(8'h10, "edge0_clr", 32'h0);

        rdc(8'h1C, "unmap_rd", 32'h0);
        wr(8'h1C, 32'hFFFF_FFFF);
        push_exp("unmap_ledr", 32'h2A5);
        check(32'(ledr));
        push_exp("unmap_hex", 32'h00AB_CDEF);
        check(32'(hex_digits));
        rdc(8'h1C, "unmap_rd2", 32'h0);
        rdc(8'h14, "unmap_en", 32'h2);
        sw = 10'h155;
        tick(1);
        rdc(8'h0C, "sw_lag", 32'h3FF);
        tick(1);
        rdc(8'h0C, "sw_sync", 32'h155);

        reset = 1'b0;
        bus.sel = 1'b1;
        bus.we = 1'b1;
        bus.addr = 8'h00;
        bus.wdata = 32'h3FF;
        tick(1);
        bus.sel = 1'b0;
        bus.we = 1'b0;
        push_exp("rst_wr_ledr", 32'h0);
        check(32'(ledr));
        rdc(8'h14, "rst_en", 32'h0);
        rdc(8'h08, "rst_key2", 32'h0);
        reset = 1'b1;
        tick(17);
        rdc(8'h08, "redet_pre", 32'h0);
        tick(1);
        rdc(8'h08, "redet_key", 32'h1);
        rdc(8'h10, "redet_edge", 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
